// File: rtl/mips_instr_encoder_if.sv
// rtl/mips_instr_encoder_if.sv - host stream, imem write port and status bundle for the encoder
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  modport master (
    output start, start_addr, in_valid, mnem, rs, rt, rd, imm, target, last,
    input  in_ready, imem_we, imem_addr, imem_wd, count, done, err
  );

  modport slave (
    input  start, start_addr, in_valid, mnem, rs, rt, rd, imm, target, last,
    output in_ready, imem_we, imem_addr, imem_wd, count, done, err
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - symbolic instruction to MIPS machine word encoder feeding imem writes
module mips_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  mips_instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;
  logic              illegal;
  logic [ADDR_W-1:0] br_off;
  logic [15:0]       br_off16;
  logic [31:0]       enc_word;

  // in_ready is a registered copy of "state is RUN", so accept needs no extra decode
  assign accept  = bus.in_ready & bus.in_valid;
  assign illegal = (bus.mnem >= 4'd12);

  // Branch offset is relative to the word after the branch, wrapped to the imem size
  always_comb begin
    br_off   = bus.imm[ADDR_W-1:0] - (wr_addr + ADDR_ONE);
    br_off16 = 16'($signed(br_off));
  end

  // Encode the current beat into a machine word; illegal mnemonics become a nop
  always_comb begin
    enc_word = 32'h0000_0000;
    case (bus.mnem)
      4'd0:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100000};
      4'd1:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100010};
      4'd2:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100100};
      4'd3:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100101};
      4'd4:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b101010};
      4'd5:  enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};
      4'd6:  enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};
      4'd7:  enc_word = {6'b000100, bus.rs, bus.rt, br_off16};
      4'd8:  enc_word = {6'b000101, bus.rs, bus.rt, br_off16};
      4'd9:  enc_word = {6'b001000, bus.rs, bus.rt, bus.imm};
      4'd10: enc_word = {6'b001101, bus.rs, bus.rt, bus.imm};
      4'd11: enc_word = {6'b000010, bus.target};
      default: enc_word = 32'h0000_0000;
    endcase
  end

  // Load FSM: all outputs registered; write strobe is a single-cycle pulse per accepted beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_addr       <= '0;
      bus.in_ready  <= 1'b0;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_wd   <= 32'h0000_0000;
      bus.count     <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state        <= S_RUN;
            bus.in_ready <= 1'b1;
            wr_addr      <= bus.start_addr;
            bus.count    <= '0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            bus.imem_we   <= 1'b1;
            bus.imem_addr <= wr_addr;
            bus.imem_wd   <= enc_word;
            wr_addr       <= wr_addr + ADDR_ONE;
            bus.count     <= bus.count + CNT_ONE;
            if (illegal) begin
              bus.err <= 1'b1;
            end
            if (bus.last) begin
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              bus.done     <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - self-checking bench for mips_instr_encoder
module tb_mips_instr_encoder;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_err;
  bit   chk_en;
  int   cyc;

  mips_instr_encoder_if #(.ADDR_W(AW)) bus ();

  mips_instr_encoder #(.ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built straight from the opcode/funct tables and field positions
  function automatic logic [31:0] m_enc(int mn, int rs, int rt, int rd, int imm, int tgt, int pc);
    longint w;
    int     op;
    int     fn;
    int     off;
    w  = 0;
    op = 0;
    fn = 0;
    case (mn)
      0: fn = 32;
      1: fn = 34;
      2: fn = 36;
      3: fn = 37;
      4: fn = 42;
      5: op = 35;
      6: op = 43;
      7: op = 4;
      8: op = 5;
      9: op = 8;
      10: op = 13;
      11: op = 2;
      default: op = 0;
    endcase
    if (mn <= 4) begin
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn;
    end else if (mn == 5 || mn == 6 || mn == 9 || mn == 10) begin
      w = longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
    end else if (mn == 7 || mn == 8) begin
      off = (((imm % DEPTH) - pc - 1) % DEPTH + DEPTH) % DEPTH;
      if (off >= DEPTH / 2) off = off - DEPTH;
      w = longint'(op) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536
          + ((off + 65536) % 65536);
    end else if (mn == 11) begin
      w = longint'(op) * 67108864 + tgt;
    end
    return w[31:0];
  endfunction

  // Cycle-level behavioural model of the loader
  int          m_run, m_done, m_err, m_count, m_addr, m_waddr;
  bit          m_we;
  logic [31:0] m_wd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_run   <= 0;
      m_done  <= 0;
      m_err   <= 0;
      m_count <= 0;
      m_addr  <= 0;
      m_we    <= 0;
      m_waddr <= 0;
      m_wd    <= 0;
    end else begin
      m_we <= 0;
      if (m_run == 0) begin
        if (bus.start) begin
          m_run   <= 1;
          m_addr  <= int'(bus.start_addr);
          m_count <= 0;
          m_done  <= 0;
          m_err   <= 0;
        end
      end else if (bus.in_valid) begin
        m_we    <= 1;
        m_waddr <= m_addr;
        m_wd    <= m_enc(int'(bus.mnem), int'(bus.rs), int'(bus.rt), int'(bus.rd),
                         int'(bus.imm), int'(bus.target), m_addr);
        m_addr  <= (m_addr + 1) % DEPTH;
        m_count <= (m_count + 1) % (2 * DEPTH);
        if (bus.mnem >= 12) m_err <= 1;
        if (bus.last) begin
          m_run  <= 0;
          m_done <= 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(m_run));
      check("imem_we", 32'(bus.imem_we), 32'(m_we));
      if (m_we) begin
        check("imem_addr", 32'(bus.imem_addr), 32'(m_waddr));
        check("imem_wd", bus.imem_wd, m_wd);
      end
      check("count", 32'(bus.count), 32'(m_count));
      check("done", 32'(bus.done), 32'(m_done));
      check("err", 32'(bus.err), 32'(m_err));
    end
  end

  // Write log for the literal expectations
  int          log_addr[$];
  logic [31:0] log_wd[$];
  int          log_cyc[$];

  always @(posedge clk) begin
    #1;
    if (bus.imem_we === 1'b1) begin
      log_addr.push_back(int'(bus.imem_addr));
      log_wd.push_back(bus.imem_wd);
      log_cyc.push_back(cyc);
    end
  end

  function automatic int find_write(int a);
    int idx;
    idx = -1;
    foreach (log_addr[i]) if (log_addr[i] == a) idx = i;
    return idx;
  endfunction

  task automatic lit_write(string name, int a, logic [31:0] wd);
    int idx;
    idx = find_write(a);
    if (idx < 0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no write seen at addr %0d, expected 0x%0h", name, a, wd);
    end else begin
      check(name, log_wd[idx], wd);
    end
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.in_valid   = 1'b0;
    bus.mnem       = '0;
    bus.rs         = '0;
    bus.rt         = '0;
    bus.rd         = '0;
    bus.imm        = '0;
    bus.target     = '0;
    bus.last       = 1'b0;
  endtask

  task automatic do_start(int a, bit iv);
    @(negedge clk);
    log_addr.delete();
    log_wd.delete();
    log_cyc.delete();
    bus.start      = 1'b1;
    bus.start_addr = AW'(a);
    bus.in_valid   = iv;
    bus.last       = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.last     = 1'b0;
  endtask

  task automatic beat(int mn, int rs_, int rt_, int rd_, int imm_, int tgt, bit lst, bit st);
    @(negedge clk);
    bus.start    = st;
    bus.in_valid = 1'b1;
    bus.mnem     = 4'(mn);
    bus.rs       = 5'(rs_);
    bus.rt       = 5'(rt_);
    bus.rd       = 5'(rd_);
    bus.imm      = 16'(imm_);
    bus.target   = 26'(tgt);
    bus.last     = lst;
  endtask

  task automatic idle(int n);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.last     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    chk_en   = 1'b0;
    cyc      = 0;
    reset_n  = 1'b0;
    clear_inputs();

    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wd", bus.imem_wd, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    check("pin_add", m_enc(0, 8, 9, 10, 0, 0, 0), 32'h0109_5020);
    check("pin_lw", m_enc(5, 0, 2, 0, 'h50, 0, 0), 32'h8C02_0050);
    check("pin_ori", m_enc(10, 4, 4, 0, 'hFF, 0, 1), 32'h3484_00FF);
    check("pin_beq", m_enc(7, 3, 7, 0, 3, 0, 5), 32'h1067_FFFD);
    check("pin_j", m_enc(11, 0, 0, 0, 0, 'h11, 6), 32'h0800_0011);

    @(negedge clk);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;

    // add, with in_valid already high in the start cycle (must not be accepted)
    do_start(0, 1'b1);
    beat(0, 8, 9, 10, 0, 0, 1'b1, 1'b0);
    idle(2);
    lit_write("t1_add", 0, 32'h0109_5020);
    check("t1_nwrites", 32'(log_addr.size()), 32'd1);
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_count", 32'(bus.count), 32'd1);

    // back-to-back stream
    do_start(0, 1'b0);
    beat(5, 0, 2, 0, 'h0050, 0, 1'b0, 1'b0);
    beat(10, 4, 4, 0, 'h00FF, 0, 1'b1, 1'b0);
    idle(2);
    lit_write("t2_lw", 0, 32'h8C02_0050);
    lit_write("t2_ori", 1, 32'h3484_00FF);
    if (log_cyc.size() == 2) check("t2_no_bubble", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
    else check("t2_nwrites", 32'(log_cyc.size()), 32'd2);

    // branch and jump; a start during RUN must be ignored
    do_start(5, 1'b0);
    beat(7, 3, 7, 0, 3, 0, 1'b0, 1'b1);
    beat(11, 0, 0, 0, 0, 'h11, 1'b1, 1'b0);
    idle(2);
    lit_write("t3_beq", 5, 32'h1067_FFFD);
    lit_write("t3_j", 6, 32'h0800_0011);

    // remaining mnemonics, model-checked
    do_start(10, 1'b0);
    beat(1, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    beat(2, 4, 5, 6, 0, 0, 1'b0, 1'b0);
    beat(3, 7, 8, 9, 0, 0, 1'b0, 1'b0);
    beat(4, 31, 30, 29, 0, 0, 1'b0, 1'b0);
    beat(6, 29, 8, 0, 'hFFFC, 0, 1'b0, 1'b0);
    beat(9, 0, 16, 0, 'h8001, 0, 1'b0, 1'b0);
    beat(8, 1, 2, 0, 2, 0, 1'b0, 1'b0);
    beat(8, 3, 4, 0, 63, 0, 1'b1, 1'b0);
    idle(2);
    lit_write("t3_bne_back", 16, 32'h1422_FFF1);

    // illegal mnem, then restart clears status
    do_start(0, 1'b0);
    beat(15, 1, 2, 3, 'h1234, 'h5678, 1'b1, 1'b0);
    idle(2);
    lit_write("t4_illegal_wd", 0, 32'h0000_0000);
    check("t4_err", 32'(bus.err), 32'd1);
    do_start(3, 1'b0);
    check("t4_err_clr", 32'(bus.err), 32'd0);
    check("t4_count_clr", 32'(bus.count), 32'd0);
    check("t4_done_clr", 32'(bus.done), 32'd0);
    beat(9, 1, 1, 0, 1, 0, 1'b1, 1'b0);
    idle(1);

    // address wrap
    do_start(63, 1'b0);
    beat(0, 1, 2, 3, 0, 0, 1'b0, 1'b0);
    beat(10, 5, 6, 0, 'h0F0F, 0, 1'b1, 1'b0);
    idle(2);
    if (log_addr.size() == 2) begin
      check("t5_addr0", 32'(log_addr[0]), 32'd63);
      check("t5_addr1", 32'(log_addr[1]), 32'd0);
    end else begin
      check("t5_nwrites", 32'(log_addr.size()), 32'd2);
    end
    check("t5_count", 32'(bus.count), 32'd2);

    // reset during an in-flight write
    do_start(20, 1'b0);
    beat(9, 2, 3, 0, 7, 0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("t6_we_before", 32'(bus.imem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_we_async", 32'(bus.imem_we), 32'd0);
    check("t6_addr", 32'(bus.imem_addr), 32'd0);
    check("t6_wd", bus.imem_wd, 32'd0);
    check("t6_count", 32'(bus.count), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_ready", 32'(bus.in_ready), 32'd0);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
